// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, datapath widths and the
// rounding-mode decoder used by the rounding controller.
package fpu_pkg;

   localparam int unsigned EXP_W   = 10;
   localparam int unsigned NMANT_W = 27;
   localparam int unsigned MANT_W  = 24;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   typedef struct packed {
      logic illegal;
      logic rmm;
      logic rtz;
      logic rup;
      logic rdn;
      logic rne;
   } rm_dec_t;

   // Expects an already-resolved mode; DYN reaching here is illegal.
   function automatic rm_dec_t rm_onehot(input logic [2:0] rm);
      rm_dec_t d;
      d = '0;
      case (rm)
         RM_RNE:  d.rne = 1'b1;
         RM_RTZ:  d.rtz = 1'b1;
         RM_RDN:  d.rdn = 1'b1;
         RM_RUP:  d.rup = 1'b1;
         RM_RMM:  d.rmm = 1'b1;
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/fpu_round_unit.sv
// Combinational rounding unit. With no mode line asserted it truncates.
module fpu_round_unit import fpu_pkg::*; (
   input  logic               in_sign,
   input  logic [EXP_W-1:0]   in_exp,
   input  logic [NMANT_W-1:0] in_mant,
   input  logic               mode_rne,
   input  logic               mode_rtz,
   input  logic               mode_rdn,
   input  logic               mode_rup,
   input  logic               mode_rmm,
   output logic [EXP_W-1:0]   res_exp,
   output logic [MANT_W-1:0]  res_mant
);

   logic          lsb, guard, rnd, sticky, inexact, inc;
   logic [MANT_W:0] sum;

   assign lsb     = in_mant[3];
   assign guard   = in_mant[2];
   assign rnd     = in_mant[1];
   assign sticky  = in_mant[0];
   assign inexact = guard | rnd | sticky;

   always_comb begin
      inc = 1'b0;
      if (mode_rne) inc = guard & (rnd | sticky | lsb);
      if (mode_rtz) inc = 1'b0;
      if (mode_rdn) inc = in_sign & inexact;
      if (mode_rup) inc = !in_sign & inexact;
      if (mode_rmm) inc = guard;
   end

   assign sum = {1'b0, in_mant[NMANT_W-1:3]} + {{MANT_W{1'b0}}, inc};

   // Carry out of the significand renormalises to 1.0 and bumps the exponent
   always_comb begin
      if (sum[MANT_W]) begin
         res_mant = {1'b1, {(MANT_W-1){1'b0}}};
         res_exp  = in_exp + 10'd1;
      end else begin
         res_mant = sum[MANT_W-1:0];
         res_exp  = in_exp;
      end
   end

endmodule

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter; the pointer advances only when a grant is issued.
module fpu_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic accept,
   output logic gnt0,
   output logic gnt1
);

   // ptr_q=1 gives requester 1 priority on a tie
   logic ptr_q, ptr_d;

   always_comb begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      if (accept) begin
         if (valid0 && valid1) begin
            gnt0 = !ptr_q;
            gnt1 = ptr_q;
         end else begin
            gnt0 = valid0;
            gnt1 = valid1;
         end
      end
      ptr_d = ptr_q;
      if (gnt0) begin
         ptr_d = 1'b1;
      end else if (gnt1) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fpu_round_ctrl.sv
// Shares the rounding unit between the add/sub (req0) and mul (req1) paths,
// resolves the rounding mode, registers the result and keeps sticky NX.
module fpu_round_ctrl import fpu_pkg::*; #(
   parameter int unsigned TAG_W     = 4,
   parameter logic [2:0]  RESET_FRM = 3'b000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic               req0_sign,
   input  logic [EXP_W-1:0]   req0_exp,
   input  logic [NMANT_W-1:0] req0_mant,
   input  logic [2:0]         req0_rm,
   input  logic [TAG_W-1:0]   req0_tag,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic               req1_sign,
   input  logic [EXP_W-1:0]   req1_exp,
   input  logic [NMANT_W-1:0] req1_mant,
   input  logic [2:0]         req1_rm,
   input  logic [TAG_W-1:0]   req1_tag,
   input  logic               frm_we,
   input  logic [2:0]         frm_wdata,
   output logic [2:0]         frm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sign,
   output logic [EXP_W-1:0]   out_exp,
   output logic [MANT_W-1:0]  out_mant,
   output logic               out_src,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_nx,
   output logic               out_illegal,
   output logic               fflags_nx,
   input  logic               fflags_clr
);

   logic               accept, gnt0, gnt1, grant, sel;
   logic               op_sign;
   logic [EXP_W-1:0]   op_exp, rnd_exp;
   logic [NMANT_W-1:0] op_mant;
   logic [2:0]         op_rm, eff_rm;
   logic [TAG_W-1:0]   op_tag;
   logic [MANT_W-1:0]  rnd_mant;
   logic               nx_next;
   rm_dec_t            rm_dec;

   // Gating with rst keeps both readies low in the reset cycle
   assign accept = !rst && (!out_valid || out_ready);

   fpu_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .accept (accept),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign grant      = gnt0 | gnt1;
   assign sel        = gnt1;

   assign op_sign = sel ? req1_sign : req0_sign;
   assign op_exp  = sel ? req1_exp  : req0_exp;
   assign op_mant = sel ? req1_mant : req0_mant;
   assign op_rm   = sel ? req1_rm   : req0_rm;
   assign op_tag  = sel ? req1_tag  : req0_tag;

   // DYN reads the registered frm, so a same-cycle write lands on the next request
   assign eff_rm  = (op_rm == RM_DYN) ? frm : op_rm;
   assign rm_dec  = rm_onehot(eff_rm);
   assign nx_next = |op_mant[2:0];

   fpu_round_unit u_round (
      .in_sign  (op_sign),
      .in_exp   (op_exp),
      .in_mant  (op_mant),
      .mode_rne (rm_dec.rne),
      .mode_rtz (rm_dec.rtz),
      .mode_rdn (rm_dec.rdn),
      .mode_rup (rm_dec.rup),
      .mode_rmm (rm_dec.rmm),
      .res_exp  (rnd_exp),
      .res_mant (rnd_mant)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         frm         <= RESET_FRM;
         fflags_nx   <= 1'b0;
         out_valid   <= 1'b0;
         out_sign    <= 1'b0;
         out_exp     <= '0;
         out_mant    <= '0;
         out_src     <= 1'b0;
         out_tag     <= '0;
         out_nx      <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         if (frm_we) frm <= frm_wdata;
         fflags_nx <= (fflags_nx && !fflags_clr) || (grant && nx_next);
         if (grant) begin
            out_valid   <= 1'b1;
            out_sign    <= op_sign;
            out_exp     <= rnd_exp;
            out_mant    <= rnd_mant;
            out_src     <= sel;
            out_tag     <= op_tag;
            out_nx      <= nx_next;
            out_illegal <= rm_dec.illegal;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fpu_round_ctrl.sv
// Self-checking bench for fpu_round_ctrl: directed scenarios plus a randomized
// run against an arithmetic reference model.
module tb_fpu_round_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sign;
   logic [9:0]  req0_exp;
   logic [26:0] req0_mant;
   logic [2:0]  req0_rm;
   logic [3:0]  req0_tag;
   logic        req1_valid, req1_ready, req1_sign;
   logic [9:0]  req1_exp;
   logic [26:0] req1_mant;
   logic [2:0]  req1_rm;
   logic [3:0]  req1_tag;
   logic        frm_we;
   logic [2:0]  frm_wdata, frm;
   logic        out_valid, out_ready, out_sign, out_src, out_nx, out_illegal;
   logic [9:0]  out_exp;
   logic [23:0] out_mant;
   logic [3:0]  out_tag;
   logic        fflags_nx, fflags_clr;

   int n_cmp = 0;
   int n_err = 0;

   fpu_round_ctrl #(.TAG_W(4), .RESET_FRM(3'b000)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sign(req0_sign),
      .req0_exp(req0_exp), .req0_mant(req0_mant), .req0_rm(req0_rm), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sign(req1_sign),
      .req1_exp(req1_exp), .req1_mant(req1_mant), .req1_rm(req1_rm), .req1_tag(req1_tag),
      .frm_we(frm_we), .frm_wdata(frm_wdata), .frm(frm),
      .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
      .out_exp(out_exp), .out_mant(out_mant), .out_src(out_src), .out_tag(out_tag),
      .out_nx(out_nx), .out_illegal(out_illegal),
      .fflags_nx(fflags_nx), .fflags_clr(fflags_clr)
   );

   always #5 clk = ~clk;

   // Reference rounding from the mode definitions, using integer arithmetic.
   function automatic void ref_round(input logic s, input logic [9:0] e, input logic [26:0] m,
                                     input logic [2:0] rm, input logic [2:0] cur_frm,
                                     output logic [9:0] re, output logic [23:0] rmant,
                                     output logic ill);
      int unsigned t, rem;
      logic [2:0]  eff;
      bit          up;
      eff = (rm == 3'b111) ? cur_frm : rm;
      ill = (eff > 3'd4);
      t   = 32'(m >> 3);
      rem = 32'(m[2:0]);
      case (eff)
         3'd0:    up = (rem > 4) || (rem == 4 && (t % 2) == 1);
         3'd2:    up = s && rem != 0;
         3'd3:    up = !s && rem != 0;
         3'd4:    up = rem >= 4;
         default: up = 1'b0;
      endcase
      t = t + (up ? 32'd1 : 32'd0);
      if (t == 32'h100_0000) begin
         t  = 32'h80_0000;
         re = e + 10'd1;
      end else begin
         re = e;
      end
      rmant = t[23:0];
   endfunction

   task automatic idle_inputs;
      req0_valid = 0; req0_sign = 0; req0_exp = '0; req0_mant = '0; req0_rm = '0; req0_tag = '0;
      req1_valid = 0; req1_sign = 0; req1_exp = '0; req1_mant = '0; req1_rm = '0; req1_tag = '0;
      frm_we = 0; frm_wdata = '0; out_ready = 1; fflags_clr = 0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1;
      req0_valid = 1; req1_valid = 1;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      idle_inputs();
      rst = 0;
      n_cmp++;
      if ({out_valid, out_sign, out_exp, out_mant, out_src, out_tag, out_nx, out_illegal}
          !== '0) begin
         n_err++; $display("FAIL reset_out: valid=%b exp=%h mant=%h tag=%h want all zero",
                           out_valid, out_exp, out_mant, out_tag);
      end
      n_cmp++;
      if (frm !== 3'b000 || fflags_nx !== 1'b0) begin
         n_err++; $display("FAIL reset_csr: frm=%b nx=%b want 000/0", frm, fflags_nx);
      end
   endtask

   task automatic test_rne_tie;
      req0_valid = 1; req0_sign = 0; req0_exp = 10'd127; req0_mant = {24'h800001, 3'b100};
      req0_rm = 3'b000; req0_tag = 4'h3;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1) begin
         n_err++; $display("FAIL rne_ready: got %b want 1", req0_ready);
      end
      @(posedge clk); #1;
      req0_valid = 0;
      n_cmp++;
      if (out_valid !== 1 || out_mant !== 24'h800002 || out_exp !== 10'd127 || out_nx !== 1
          || out_src !== 0 || out_tag !== 4'h3 || out_illegal !== 0) begin
         n_err++; $display("FAIL rne_tie: v=%b mant=%h exp=%0d nx=%b src=%b tag=%h want 1 800002 127 1 0 3",
                           out_valid, out_mant, out_exp, out_nx, out_src, out_tag);
      end
      n_cmp++;
      if (fflags_nx !== 1'b1) begin
         n_err++; $display("FAIL rne_fflags: got %b want 1", fflags_nx);
      end
   endtask

   task automatic test_overflow;
      req1_valid = 1; req1_sign = 0; req1_exp = 10'd127; req1_mant = {24'hFFFFFF, 3'b111};
      req1_rm = 3'b011; req1_tag = 4'h9;
      @(posedge clk); #1;
      req1_valid = 0;
      n_cmp++;
      if (out_valid !== 1 || out_mant !== 24'h800000 || out_exp !== 10'd128 || out_src !== 1
          || out_tag !== 4'h9) begin
         n_err++; $display("FAIL overflow: v=%b mant=%h exp=%0d src=%b tag=%h want 1 800000 128 1 9",
                           out_valid, out_mant, out_exp, out_src, out_tag);
      end
   endtask

   task automatic test_dyn_frm;
      frm_we = 1; frm_wdata = 3'b001;
      @(posedge clk); #1;
      n_cmp++;
      if (frm !== 3'b001) begin
         n_err++; $display("FAIL dyn_frm_write: got %b want 001", frm);
      end
      req0_valid = 1; req0_sign = 0; req0_exp = 10'd5; req0_mant = {24'h800001, 3'b110};
      req0_rm = 3'b111; req0_tag = 4'h1; frm_wdata = 3'b000;
      @(posedge clk); #1;
      frm_we = 0;
      n_cmp++;
      if (out_mant !== 24'h800001 || frm !== 3'b000) begin
         n_err++; $display("FAIL dyn_old_frm: mant=%h frm=%b want 800001 000", out_mant, frm);
      end
      @(posedge clk); #1;
      req0_valid = 0;
      n_cmp++;
      if (out_mant !== 24'h800002 || out_valid !== 1) begin
         n_err++; $display("FAIL dyn_new_frm: mant=%h v=%b want 800002 1", out_mant, out_valid);
      end
   endtask

   task automatic test_fairness;
      do_reset();
      req0_valid = 1; req0_tag = 4'hA; req0_mant = 27'd8;
      req1_valid = 1; req1_tag = 4'h5; req1_mant = 27'd16;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1 || out_src !== k[0] || out_tag !== (k[0] ? 4'h5 : 4'hA)) begin
            n_err++; $display("FAIL fairness[%0d]: v=%b src=%b tag=%h want 1 %b %h", k,
                              out_valid, out_src, out_tag, k[0], k[0] ? 4'h5 : 4'hA);
         end
      end
      req0_valid = 0; req1_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      req0_valid = 1; req0_sign = 1; req0_exp = 10'd50; req0_mant = {24'h123456, 3'b000};
      req0_rm = 3'b001; req0_tag = 4'h1;
      @(posedge clk); #1;
      // req0 granted last, so req1 must win once the stall releases
      out_ready = 0;
      req0_tag = 4'h2; req0_mant = {24'h111111, 3'b000};
      req1_valid = 1; req1_sign = 0; req1_exp = 10'd60; req1_mant = {24'h654321, 3'b000};
      req1_rm = 3'b000; req1_tag = 4'h7;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (req0_ready !== 0 || req1_ready !== 0) begin
            n_err++; $display("FAIL bp_ready[%0d]: got %b%b want 00", k, req0_ready, req1_ready);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1 || out_sign !== 1 || out_exp !== 10'd50 || out_mant !== 24'h123456
             || out_tag !== 4'h1 || out_src !== 0) begin
            n_err++; $display("FAIL bp_hold[%0d]: v=%b exp=%0d mant=%h tag=%h want 1 50 123456 1",
                              k, out_valid, out_exp, out_mant, out_tag);
         end
      end
      out_ready = 1;
      #1;
      n_cmp++;
      if (req1_ready !== 1 || req0_ready !== 0) begin
         n_err++; $display("FAIL bp_release_ready: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      n_cmp++;
      if (out_valid !== 1 || out_tag !== 4'h7 || out_src !== 1 || out_mant !== 24'h654321
          || out_exp !== 10'd60) begin
         n_err++; $display("FAIL bp_release: v=%b tag=%h src=%b mant=%h want 1 7 1 654321",
                           out_valid, out_tag, out_src, out_mant);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_illegal_clear;
      req0_valid = 1; req0_sign = 0; req0_exp = 10'd3; req0_mant = {24'h000010, 3'b111};
      req0_rm = 3'b101; req0_tag = 4'hC;
      @(posedge clk); #1;
      req0_valid = 0;
      n_cmp++;
      if (out_illegal !== 1 || out_mant !== 24'h000010 || out_exp !== 10'd3 || out_nx !== 1) begin
         n_err++; $display("FAIL illegal: ill=%b mant=%h exp=%0d nx=%b want 1 000010 3 1",
                           out_illegal, out_mant, out_exp, out_nx);
      end
      fflags_clr = 1;
      @(posedge clk); #1;
      fflags_clr = 0;
      n_cmp++;
      if (fflags_nx !== 1'b0) begin
         n_err++; $display("FAIL fflags_clr: got %b want 0", fflags_nx);
      end
   endtask

   task automatic test_reset_mid;
      req0_valid = 1; req0_mant = {24'h400000, 3'b001}; req0_exp = 10'd9; req0_tag = 4'hE;
      out_ready = 0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1) begin
         n_err++; $display("FAIL rstmid_setup: out_valid=%b want 1", out_valid);
      end
      rst = 1; out_ready = 1;
      #1;
      n_cmp++;
      if (req0_ready !== 0) begin
         n_err++; $display("FAIL rstmid_ready: got %b want 0", req0_ready);
      end
      @(posedge clk); #1;
      rst = 0; req0_valid = 0;
      n_cmp++;
      if (out_valid !== 0 || out_mant !== 24'h0 || out_tag !== 4'h0 || fflags_nx !== 0) begin
         n_err++; $display("FAIL rstmid: v=%b mant=%h tag=%h nx=%b want 0 0 0 0",
                           out_valid, out_mant, out_tag, fflags_nx);
      end
   endtask

   task automatic test_random;
      logic       m_valid, m_last, m_fnx, m_sign, m_src, m_nx, m_ill, acc, e0, e1, sel;
      logic [2:0] m_frm;
      logic [9:0] m_exp;
      logic [23:0] m_mant;
      logic [3:0] m_tag;
      do_reset();
      m_valid = 0; m_last = 1; m_fnx = 0; m_sign = 0; m_src = 0; m_nx = 0; m_ill = 0;
      m_frm = 3'b000; m_exp = '0; m_mant = '0; m_tag = '0;
      for (int i = 0; i < 400; i++) begin
         req0_valid = 1'($urandom); req0_sign = 1'($urandom); req0_exp = 10'($urandom);
         req0_mant = 27'($urandom); req0_rm = 3'($urandom); req0_tag = 4'($urandom);
         req1_valid = 1'($urandom); req1_sign = 1'($urandom); req1_exp = 10'($urandom);
         req1_mant = 27'($urandom); req1_rm = 3'($urandom); req1_tag = 4'($urandom);
         if ($urandom_range(0, 7) == 0) req0_mant[26:3] = '1;
         if ($urandom_range(0, 7) == 0) req1_mant[26:3] = '1;
         out_ready = ($urandom_range(0, 3) != 0);
         frm_we = ($urandom_range(0, 5) == 0); frm_wdata = 3'($urandom);
         fflags_clr = ($urandom_range(0, 9) == 0);
         #1;
         acc = !m_valid || out_ready;
         e0 = 0; e1 = 0;
         if (acc) begin
            if (req0_valid && req1_valid) begin
               e0 = m_last; e1 = !m_last;
            end else begin
               e0 = req0_valid; e1 = req1_valid;
            end
         end
         n_cmp++;
         if (req0_ready !== e0 || req1_ready !== e1) begin
            n_err++; $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i,
                              req0_ready, req1_ready, e0, e1);
         end
         m_fnx = m_fnx && !fflags_clr;
         if (e0 || e1) begin
            sel = e1;
            m_src = sel; m_last = sel; m_valid = 1;
            m_sign = sel ? req1_sign : req0_sign;
            m_tag  = sel ? req1_tag : req0_tag;
            m_nx   = sel ? (req1_mant[2:0] != 0) : (req0_mant[2:0] != 0);
            if (sel) ref_round(req1_sign, req1_exp, req1_mant, req1_rm, m_frm, m_exp, m_mant, m_ill);
            else     ref_round(req0_sign, req0_exp, req0_mant, req0_rm, m_frm, m_exp, m_mant, m_ill);
            m_fnx = m_fnx || m_nx;
         end else if (out_ready) begin
            m_valid = 0;
         end
         if (frm_we) m_frm = frm_wdata;
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== m_valid || out_sign !== m_sign || out_exp !== m_exp
             || out_mant !== m_mant || out_src !== m_src || out_tag !== m_tag
             || out_nx !== m_nx || out_illegal !== m_ill) begin
            n_err++;
            $display("FAIL rand_out[%0d]: got v%b s%b e%h m%h src%b t%h nx%b il%b want v%b s%b e%h m%h src%b t%h nx%b il%b",
                     i, out_valid, out_sign, out_exp, out_mant, out_src, out_tag, out_nx,
                     out_illegal, m_valid, m_sign, m_exp, m_mant, m_src, m_tag, m_nx, m_ill);
         end
         n_cmp++;
         if (frm !== m_frm || fflags_nx !== m_fnx) begin
            n_err++; $display("FAIL rand_csr[%0d]: got frm=%b nx=%b want %b %b", i,
                              frm, fflags_nx, m_frm, m_fnx);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_rne_tie();
      test_overflow();
      test_dyn_frm();
      test_fairness();
      test_backpressure();
      test_illegal_clear();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
